// File: rtl/kgp_pkg.sv
// Shared constants for the register file slice: widths, register count and
// architecturally special register numbers.
package kgp_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;
endpackage

// File: rtl/reg_writeback_file_addr_decoder5to32.sv
// Enable-gated 5-to-32 one-hot decoder; all outputs are low when en is low.
import kgp_pkg::*;

module addr_decoder5to32 (
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end
endmodule

// File: rtl/reg_writeback_file.sv
// 32-entry register file with a same-cycle writeback bypass and a busy
// scoreboard that stalls issue while a source still has a pending write.
import kgp_pkg::*;

module reg_writeback_file #(
    parameter int DATA_W = kgp_pkg::DATA_W,
    parameter int ADDR_W = kgp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wr_onehot;
    logic [NUM_REGS-1:0] iss_onehot;
    logic                rs_bypass;
    logic                rt_bypass;
    logic                iss_accept;

    assign rs_bypass  = wr_en && (wr_addr == rs_addr) && (rs_addr != ADDR_W'(REG_ZERO));
    assign rt_bypass  = wr_en && (wr_addr == rt_addr) && (rt_addr != ADDR_W'(REG_ZERO));
    assign stall      = ((rs_addr != ADDR_W'(REG_ZERO)) && busy[rs_addr] && !rs_bypass) ||
                        ((rt_addr != ADDR_W'(REG_ZERO)) && busy[rt_addr] && !rt_bypass);
    assign iss_accept = iss_en && !stall;

    addr_decoder5to32 u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    addr_decoder5to32 u_iss_dec (
        .en     (iss_accept),
        .addr   (iss_addr),
        .onehot (iss_onehot)
    );

    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (rs_addr == ADDR_W'(REG_ZERO)) begin
            rs_data = '0;
        end else if (rs_bypass) begin
            rs_data = wr_data;
        end
        if (rt_addr == ADDR_W'(REG_ZERO)) begin
            rt_data = '0;
        end else if (rt_bypass) begin
            rt_data = wr_data;
        end
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Issue is applied after the writeback clear so a newer producer keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~wr_onehot) | iss_onehot) & ~(NUM_REGS'(1) << REG_ZERO);
        end
    end
endmodule

// File: tb/tb_reg_writeback_file.sv
// Directed table-driven bench for reg_writeback_file plus hand-written
// reset sequences.
module tb_reg_writeback_file;
    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall;

    int total;
    int bad;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iss;
        logic [4:0]  iss_a;
        logic        wr;
        logic [4:0]  wr_a;
        logic [31:0] wr_d;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic        exp_stall;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    reg_writeback_file dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic iss, input logic [4:0] iss_a,
                                input logic wr, input logic [4:0] wr_a, input logic [31:0] wr_d,
                                input logic [31:0] exp_rs, input logic [31:0] exp_rt,
                                input logic exp_stall);
        vec_t v;
        v.rs = rs; v.rt = rt; v.iss = iss; v.iss_a = iss_a;
        v.wr = wr; v.wr_a = wr_a; v.wr_d = wr_d;
        v.exp_rs = exp_rs; v.exp_rt = exp_rt; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rs_addr  = v.rs;
        rt_addr  = v.rt;
        iss_en   = v.iss;
        iss_addr = v.iss_a;
        wr_en    = v.wr;
        wr_addr  = v.wr_a;
        wr_data  = v.wr_d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_rs,
                               input logic [31:0] exp_rt, input logic exp_stall);
        total++;
        if (rs_data !== exp_rs) begin
            bad++;
            $display("[TB] FAIL %s rs_data: got %h expected %h", name, rs_data, exp_rs);
        end
        total++;
        if (rt_data !== exp_rt) begin
            bad++;
            $display("[TB] FAIL %s rt_data: got %h expected %h", name, rt_data, exp_rt);
        end
        total++;
        if (stall !== exp_stall) begin
            bad++;
            $display("[TB] FAIL %s stall: got %b expected %b", name, stall, exp_stall);
        end
    endtask

    task automatic idle();
        applyStimulus(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();

        // Expected values below assume the file starts from reset.
        vecs[0]  = mk(5'd3,  5'd0,  1'b0, 5'd0,  1'b1, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0);
        vecs[1]  = mk(5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        1'b0);
        vecs[2]  = mk(5'd0,  5'd3,  1'b0, 5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[3]  = mk(5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0);
        vecs[4]  = mk(5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0);
        vecs[5]  = mk(5'd0,  5'd0,  1'b1, 5'd31, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0);
        vecs[6]  = mk(5'd0,  5'd31, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b1);
        vecs[7]  = mk(5'd0,  5'd31, 1'b0, 5'd0,  1'b1, 5'd31, 32'h40,       32'h0,        32'h40,       1'b0);
        vecs[8]  = mk(5'd0,  5'd31, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h40,       1'b0);
        vecs[9]  = mk(5'd0,  5'd0,  1'b1, 5'd7,  1'b1, 5'd7,  32'h77,       32'h0,        32'h0,        1'b0);
        vecs[10] = mk(5'd7,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h77,       32'h0,        1'b1);
        vecs[11] = mk(5'd7,  5'd0,  1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        32'h77,       32'h0,        1'b1);
        vecs[12] = mk(5'd9,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0);
        vecs[13] = mk(5'd7,  5'd0,  1'b0, 5'd0,  1'b1, 5'd7,  32'h78,       32'h78,       32'h0,        1'b0);
        vecs[14] = mk(5'd7,  5'd3,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h78,       32'hDEADBEEF, 1'b0);
        vecs[15] = mk(5'd5,  5'd4,  1'b0, 5'd0,  1'b1, 5'd4,  32'hA5,       32'h0,        32'hA5,       1'b0);
        vecs[16] = mk(5'd4,  5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'hA5,       32'h0,        1'b0);

        repeat (2) @(posedge clk);
        #1;
        rs_addr = 5'd3;
        rt_addr = 5'd31;
        #1;
        checkOutput("in_reset", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("after_reset", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_stall);
            @(posedge clk);
            #1;
        end

        // Load reg5 with 0x1234 and mark it busy, then pulse reset between edges.
        applyStimulus(mk(5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0));
        @(posedge clk);
        #1;
        idle();
        rs_addr = 5'd5;
        #1;
        checkOutput("busy5_before_rst", 32'h1234, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_pulse_during", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rst_pulse_after", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_pulse_next_cycle", 32'h0, 32'h0, 1'b0);

        // Reset held across an edge must swallow a write and an issue.
        applyStimulus(mk(5'd0, 5'd0, 1'b1, 5'd6, 1'b1, 5'd6, 32'h66, 32'h0, 32'h0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        rs_addr = 5'd6;
        rt_addr = 5'd4;
        #1;
        checkOutput("rst_edge_discard", 32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/reg_writeback_file.md
REG_WRITEBACK_FILE -- requirements
Module: reg_writeback_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rs_addr  input  ADDR_W  read port A address.
REQ-006 SHALL have port rt_addr  input  ADDR_W  read port B address.
REQ-007 SHALL have port rs_data  output  DATA_W  read port A data.
REQ-008 SHALL have port rt_data  output  DATA_W  read port B data.
REQ-009 SHALL have port iss_en  input  1  issue request: an instruction targeting iss_addr enters the pipeline.
REQ-010 SHALL have port iss_addr  input  ADDR_W  destination register of the issuing instruction (from the destination-select mux).
REQ-011 SHALL have port wr_en  input  1  writeback strobe.
REQ-012 SHALL have port wr_addr  input  ADDR_W  writeback destination register.
REQ-013 SHALL have port wr_data  input  DATA_W  writeback data.
REQ-014 SHALL have port stall  output  1  high when a source register has a pending, not-yet-completing write.

Function
REQ-015 SHALL hold 32 x DATA_W registers plus a 32-bit busy vector.
REQ-016 SHALL read combinationally (zero latency): rs_data = reg[rs_addr], rt_data = reg[rt_addr].
REQ-017 SHALL bypass: if wr_en and wr_addr == rs_addr (or rt_addr) and the address is nonzero, the corresponding output equals wr_data in the same cycle.
REQ-018 SHALL treat register 0 as constant zero: reads return 0, writes ignored, busy[0] never set.
REQ-019 SHALL write reg[wr_addr] <= wr_data at the rising edge when wr_en = 1 and wr_addr != 0.
REQ-020 SHALL assert stall = (rs_addr != 0 and busy[rs_addr] and not (wr_en and wr_addr == rs_addr)) or the same term for rt_addr.
REQ-021 SHALL accept an issue only when iss_en = 1 and stall = 0; an accepted issue sets busy[iss_addr] (iss_addr != 0) at the edge.
REQ-022 SHALL clear busy[wr_addr] at the edge when wr_en = 1, unless an accepted issue to the same address occurs that cycle, in which case busy stays 1 (newer producer wins).
REQ-023 SHALL ignore iss_en while stall = 1 (no busy change from issue that cycle; writeback still processed).
REQ-024 SHALL decode wr_addr and iss_addr to one-hot 32-bit enables; only the addressed register/busy bit changes.
REQ-025 SHALL process wr_en with wr_addr == 0 as no register write and no busy change.

Reset
REQ-026 SHALL, while rst = 1, asynchronously clear all 32 registers to 0 and the busy vector to 0.
REQ-027 SHALL, after reset, present rs_data = 0, rt_data = 0 (no bypass active), stall = 0.
REQ-028 SHALL, on rst asserted mid-operation, discard pending writes and issues that cycle; no write occurs at an edge where rst = 1.

Structure
REQ-029 SHALL take DATA_W, ADDR_W, NUM_REGS = 32, REG_ZERO = 0 and REG_RA = 31 from the shared package kgp_pkg.
REQ-030 SHALL instantiate sub-module addr_decoder5to32 (5-bit address to 32-bit one-hot, enable-gated) twice: writeback and issue.
REQ-031 SHALL contain no other sub-modules; storage and busy logic are local.

Verification
REQ-032 SHALL cover reset: pulse rst between edges with reg[5] = 0x1234 and busy[5] = 1 -> rs_addr = 5 gives rs_data = 0, stall = 0 immediately.
REQ-033 SHALL cover write/read: wr_en = 1, wr_addr = 3, wr_data = 0xDEADBEEF, rs_addr = 3 -> rs_data = 0xDEADBEEF same cycle (bypass) and after the edge.
REQ-034 SHALL cover register 0: wr_en = 1, wr_addr = 0, wr_data = 0xFFFFFFFF, then iss_addr = 0 -> rs_addr = 0 reads 0, stall = 0.
REQ-035 SHALL cover hazard: issue iss_addr = 31, next cycle rt_addr = 31 -> stall = 1; wr_en = 1, wr_addr = 31, wr_data = 0x40 -> stall = 0 that cycle, rt_data = 0x40.
REQ-036 SHALL cover simultaneous issue and writeback to 7 with stall = 0 -> reg[7] = wr_data, busy[7] remains 1, rs_addr = 7 stalls next cycle.
REQ-037 SHALL cover issue under stall: stall = 1, iss_en = 1, iss_addr = 9 -> busy[9] unchanged (rs_addr = 9 later shows stall = 0).
